// File: rtl/handshake_receiver_if.sv
// Bus bundle between the two send/ack senders, the receiver and the merged output consumer.
interface handshake_receiver_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 3
);
  logic [DATA_W-1:0] data1, data2, out_data;
  logic              send1, ack1, send2, ack2;
  logic              out_src, out_valid, out_ready;
  logic [CNT_W-1:0]  cnt1, cnt2;

  modport master (
    output data1, send1, data2, send2, out_ready,
    input  ack1, ack2, out_data, out_src, out_valid, cnt1, cnt2
  );
  modport slave (
    input  data1, send1, data2, send2, out_ready,
    output ack1, ack2, out_data, out_src, out_valid, cnt1, cnt2
  );
endinterface

// File: rtl/handshake_receiver.sv
// Two four-phase send/ack receivers, each with its own FIFO, merged round-robin
// into one tagged valid/ready stream.
module handshake_receiver_chan #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              send,
  input  logic              pop,
  output logic              ack,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic [CNT_W-1:0]  cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic {IDLE, ACK} state_t;

   state_t                             state;
   logic [FIFO_DEPTH-1:0][DATA_W-1:0]  mem;
   logic [AW-1:0]                      wp, rp;
   logic                               full, push;

   // full looks at the pre-edge count, so a same-edge pop never frees a slot
   assign full  = (cnt == CNT_W'(FIFO_DEPTH));
   assign empty = (cnt == '0);
   assign push  = (state == IDLE) && send && !full;
   assign head  = mem[rp];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ack   <= 1'b0;
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (push) begin
               state <= ACK;
               ack   <= 1'b1;
            end
            ACK: if (!send) begin
               state <= IDLE;
               ack   <= 1'b0;
            end
            default: begin
               state <= IDLE;
               ack   <= 1'b0;
            end
         endcase
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= data;
   end
endmodule

module handshake_receiver #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input logic                 clk,
  input logic                 rst_n,
  handshake_receiver_if.slave bus
);
   localparam int NUM_CH = 2;

   logic [NUM_CH-1:0][DATA_W-1:0] din, head;
   logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
   logic [NUM_CH-1:0]             send, ack, empty, pop;
   logic                          prio, load, sel;
   logic                          out_valid_q, out_src_q;
   logic [DATA_W-1:0]             out_data_q;

   assign din  = {bus.data2, bus.data1};
   assign send = {bus.send2, bus.send1};

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      handshake_receiver_chan #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
      ) u_ch (
        .clk(clk), .rst_n(rst_n), .data(din[c]), .send(send[c]), .pop(pop[c]),
        .ack(ack[c]), .head(head[c]), .empty(empty[c]), .cnt(cnt[c])
      );
   end

   // prio only matters when both heads compete; otherwise take whichever is non-empty
   assign load   = (!out_valid_q || bus.out_ready) && !(&empty);
   assign sel    = (!empty[0] && !empty[1]) ? prio : empty[0];
   assign pop[0] = load && !sel;
   assign pop[1] = load && sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_src_q   <= 1'b0;
         out_data_q  <= '0;
         prio        <= 1'b0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_src_q   <= sel;
         out_data_q  <= head[sel];
         prio        <= !sel;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.ack1      = ack[0];
   assign bus.ack2      = ack[1];
   assign bus.cnt1      = cnt[0];
   assign bus.cnt2      = cnt[1];
   assign bus.out_valid = out_valid_q;
   assign bus.out_src   = out_src_q;
   assign bus.out_data  = out_data_q;
endmodule
